// File: rtl/data_ram_sync_if.sv
// -----------------------------------------------------------------------------
// data_ram_sync_if
//   Request/response bus between a requester (execute stage) and the
//   data_ram_sync memory.
//
//   req_valid  requester -> memory   request present
//   req_ready  memory -> requester   memory can take a request this cycle
//   req_we     requester -> memory   1 = write, 0 = read
//   req_addr   requester -> memory   word address
//   req_wdata  requester -> memory   write data
//   req_be     requester -> memory   byte enables, bit i covers wdata[8i+7:8i]
//   rsp_valid  memory -> requester   one-cycle response strobe per request
//   rsp_rdata  memory -> requester   response data (read data or merged word)
// -----------------------------------------------------------------------------
interface data_ram_sync_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/data_ram_sync.sv
// -----------------------------------------------------------------------------
// data_ram_sync
//   Single-port synchronous data memory with byte enables and a 1-cycle
//   registered response. After reset, or on an init_req pulse while idle, an
//   init sequencer sweeps every word: INIT_VAL into 0..DEPTH-2 and LAST_INIT
//   into DEPTH-1. Requests are refused while the sweep runs.
//
//   clk       clock, all state on the rising edge
//   rst_n     asynchronous active-low reset
//   init_req  pulse: restart the init sweep (honoured only when idle)
//   busy      1 while the init sweep is running
//   bus       data_ram_sync_if.slave request/response port
// -----------------------------------------------------------------------------
module data_ram_sync #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 4,
  parameter logic [DATA_W-1:0] INIT_VAL  = '0,
  parameter logic [DATA_W-1:0] LAST_INIT = DATA_W'(5)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           init_req,
  output logic           busy,
  data_ram_sync_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("data_ram_sync: DATA_W must be a multiple of 8");
  end

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t              state;
  // One bit wider than the address so the sweep end is an explicit compare,
  // never a wrap back to zero.
  logic [ADDR_W:0]     init_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                init_last;
  logic [DATA_W-1:0]   init_word;
  logic [DATA_W-1:0]   cur_word;
  logic [DATA_W-1:0]   merged_word;

  // Ready depends on state only, so a requester may hold valid without a
  // combinational loop through this block.
  assign bus.req_ready = (state == ST_IDLE);
  assign busy          = (state == ST_INIT);
  assign accept        = bus.req_valid & bus.req_ready;

  assign init_last = (init_cnt == (ADDR_W+1)'(DEPTH - 1));
  assign init_word = init_last ? LAST_INIT : INIT_VAL;
  assign cur_word  = mem[bus.req_addr];

  // Write-first merge: the word the array will hold after this request. For a
  // read, or a write with no byte enables, it is simply the current word.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    merged_word = cur_word;
    for (int i = 0; i < NB; i++) begin
      if (bus.req_we && bus.req_be[i]) begin
        merged_word[8*i +: 8] = bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM and registered response.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_INIT;
      init_cnt      <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      bus.rsp_valid <= accept;
      if (accept) begin
        bus.rsp_rdata <= merged_word;
      end

      case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_last) begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          // A request accepted in this same cycle still completes above; the
          // sweep that starts next cycle then overwrites the array.
          if (init_req) begin
            state    <= ST_INIT;
            init_cnt <= '0;
          end
        end
        default: begin
          state    <= ST_INIT;
          init_cnt <= '0;
        end
      endcase
    end
  end

  // Storage array: distributed RAM, one write port, asynchronous read.
  // NOTE: the array has no reset; it maps onto LUT RAM, and its contents are
  // defined by the init sweep rather than by rst_n.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[init_cnt[ADDR_W-1:0]] <= init_word;
    end else if (accept && bus.req_we) begin
      mem[bus.req_addr] <= merged_word;
    end
  end

endmodule

// File: tb/tb_data_ram_sync.sv
module tb_data_ram_sync;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic init_req;
  logic busy;

  data_ram_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  data_ram_sync #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_VAL (16'h0000),
    .LAST_INIT(16'h0005)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .init_req(init_req),
    .busy    (busy),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] exp_q [$];

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
    logic [DATA_W-1:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(bus.rsp_rdata), 32'hDEAD_0000);
      end else begin
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drive one request at the current (post-edge) time and consume one edge.
  task automatic issue(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, input logic [1:0] be,
                       input logic [DATA_W-1:0] exp);
    check("req_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    exp_q.push_back(exp);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Count edges until busy drops; ready must stay low throughout.
  task automatic wait_init(input string name);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 100) begin
      check("ready_low_in_init", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
      cnt++;
    end
    check(name, 32'(cnt), 32'(DEPTH));
    check("ready_after_init", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      32'(busy),          32'd1);
    check({tag, "_ready"},     32'(bus.req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
  endtask

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{1'b0, 4'hF, 16'h0000, 2'b00, 16'h0005};
    vecs[1]  = '{1'b0, 4'h0, 16'h0000, 2'b00, 16'h0000};
    vecs[2]  = '{1'b1, 4'h3, 16'hABCD, 2'b11, 16'hABCD};
    vecs[3]  = '{1'b1, 4'h3, 16'h1234, 2'b01, 16'hAB34};
    vecs[4]  = '{1'b0, 4'h3, 16'h0000, 2'b00, 16'hAB34};
    vecs[5]  = '{1'b1, 4'h7, 16'h00FF, 2'b11, 16'h00FF};
    vecs[6]  = '{1'b0, 4'h7, 16'h0000, 2'b00, 16'h00FF};
    vecs[7]  = '{1'b1, 4'h7, 16'hFFFF, 2'b00, 16'h00FF};
    vecs[8]  = '{1'b0, 4'h7, 16'h0000, 2'b00, 16'h00FF};
    vecs[9]  = '{1'b1, 4'h5, 16'hBEEF, 2'b10, 16'hBE00};
    vecs[10] = '{1'b0, 4'h5, 16'h0000, 2'b00, 16'hBE00};

    rst_n         = 1'b0;
    init_req      = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;

    // Reset held three cycles, then the sweep must last exactly DEPTH cycles.
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_init("init_len_after_reset");

    // Table vectors issued back to back.
    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp);
    end
    idle();
    // Cycle after a non-accept: no response, data held.
    check("gap_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("gap_rsp_hold",  32'(bus.rsp_rdata), 32'h0000BE00);

    // init_req with a concurrent read: the read still completes.
    init_req = 1'b1;
    issue(1'b0, 4'h7, 16'h0000, 2'b00, 16'h00FF);
    init_req      = 1'b0;
    bus.req_valid = 1'b0;
    check("busy_after_init_req", 32'(busy), 32'd1);
    wait_init("init_len_after_req");
    issue(1'b0, 4'h3, 16'h0000, 2'b00, 16'h0000);
    issue(1'b0, 4'h5, 16'h0000, 2'b00, 16'h0000);
    issue(1'b0, 4'hF, 16'h0000, 2'b00, 16'h0005);
    idle();

    // Reset in the middle of a sweep, with a write request held during INIT.
    init_req = 1'b1;
    @(posedge clk); #1;
    init_req      = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 4'h3;
    bus.req_wdata = 16'hFFFF;
    bus.req_be    = 2'b11;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_sweep_reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init("init_len_after_mid_reset");
    issue(1'b0, 4'h3, 16'h0000, 2'b00, 16'h0000);
    issue(1'b0, 4'hF, 16'h0000, 2'b00, 16'h0005);
    idle();
    idle();

    check("responses_outstanding", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
